// File: rtl/step_run_ctrl.sv
// ---------------------------------------------------------------------------
// step_run_ctrl
//
// Execution controller that sits in front of the processor's PC-enable input.
// Debounced button ticks are turned into one-cycle PC-enable pulses in one of
// three ways:
//   - single-step: each step tick in IDLE (or BREAK) issues one pulse;
//   - free-run: in RUN a pulse is issued every RATE_DIVn clocks, where n is
//     chosen by rate_sel (which may change while running);
//   - breakpoint: while running, a match of mon_pc against bp_addr parks the
//     controller in BREAK without issuing a pulse.
// It also reports run/halt status and counts the pulses it has issued.
//
// Optional feature macro: STEP_RUN_BREAKPOINT_EN
//   defined   : breakpoint compare, BREAK state and resume-skip logic present.
//   undefined : bp_en, bp_addr and mon_pc are ignored, BREAK is unreachable,
//               halted_bp is tied low and the skip register does not exist.
//
// Ports
//   clk        in   1     system clock
//   reset      in   1     asynchronous, active-low reset
//   step_tick  in   1     one-cycle pulse: request a single step
//   run_tick   in   1     one-cycle pulse: toggle run/stop
//   rate_sel   in   2     selects the free-run period RATE_DIV0..3
//   bp_en      in   1     breakpoint enable
//   bp_addr    in   PC_W  breakpoint PC value
//   mon_pc     in   PC_W  current PC from the processor
//   pc_en      out  1     one-cycle PC-enable pulse (registered)
//   running    out  1     high while in RUN (registered)
//   halted_bp  out  1     high while in BREAK (registered)
//   step_cnt   out  PC_W  number of pc_en pulses issued, wraps at the top
// ---------------------------------------------------------------------------
module step_run_ctrl #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned DIV_W     = 27,
  parameter int unsigned RATE_DIV0 = 100_000_000,
  parameter int unsigned RATE_DIV1 = 10_000_000,
  parameter int unsigned RATE_DIV2 = 1_000_000,
  parameter int unsigned RATE_DIV3 = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step_tick,
  input  logic            run_tick,
  input  logic [1:0]      rate_sel,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] mon_pc,
  output logic            pc_en,
  output logic            running,
  output logic            halted_bp,
  output logic [PC_W-1:0] step_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } state_e;

  // The divider counts 0..RATE_DIVn-1, so the terminal values are stored
  // already decremented.
  localparam logic [DIV_W-1:0] LIM0 = DIV_W'(RATE_DIV0 - 1);
  localparam logic [DIV_W-1:0] LIM1 = DIV_W'(RATE_DIV1 - 1);
  localparam logic [DIV_W-1:0] LIM2 = DIV_W'(RATE_DIV2 - 1);
  localparam logic [DIV_W-1:0] LIM3 = DIV_W'(RATE_DIV3 - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [DIV_W-1:0] rateLimit;
  logic             pcEn_q, pcEn_d;
  logic             running_q;
  logic [PC_W-1:0]  stepCnt_q, stepCnt_d;

`ifdef STEP_RUN_BREAKPOINT_EN
  logic skip_q, skip_d;
  logic halted_q;
  logic bpHit;

  // skip masks the compare after a resume so that the PC still sitting on
  // the breakpoint does not immediately re-trigger it.
  assign bpHit = bp_en && !skip_q && (mon_pc == bp_addr);
`else
  logic bpInputs_unused;

  assign bpInputs_unused = ^{bp_en, bp_addr, mon_pc};
`endif

  always_comb begin
    rateLimit = LIM0;
    case (rate_sel)
      2'd0:    rateLimit = LIM0;
      2'd1:    rateLimit = LIM1;
      2'd2:    rateLimit = LIM2;
      default: rateLimit = LIM3;
    endcase
  end

  // Next-state decision. run_tick has priority over step_tick in every state,
  // and in RUN the breakpoint is examined before the divider so a match never
  // lets a pulse out on the same cycle. The >= compare lets a mid-run switch
  // to a faster rate fire at once instead of waiting for the divider to wrap.
  always_comb begin
    state_d  = state_q;
    divCnt_d = divCnt_q;
    pcEn_d   = 1'b0;
`ifdef STEP_RUN_BREAKPOINT_EN
    skip_d   = skip_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run_tick) begin
          state_d  = ST_RUN;
          divCnt_d = '0;
        end else if (step_tick) begin
          pcEn_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_tick) begin
          state_d  = ST_IDLE;
          divCnt_d = '0;
        end
`ifdef STEP_RUN_BREAKPOINT_EN
        else if (bpHit) begin
          state_d  = ST_BREAK;
          divCnt_d = '0;
        end
`endif
        else if (divCnt_q >= rateLimit) begin
          pcEn_d   = 1'b1;
          divCnt_d = '0;
`ifdef STEP_RUN_BREAKPOINT_EN
          skip_d   = 1'b0;
`endif
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
`ifdef STEP_RUN_BREAKPOINT_EN
      ST_BREAK: begin
        if (run_tick) begin
          state_d  = ST_RUN;
          divCnt_d = '0;
          skip_d   = 1'b1;
        end else if (step_tick) begin
          state_d = ST_IDLE;
          pcEn_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        divCnt_d = '0;
      end
    endcase

    stepCnt_d = stepCnt_q;
    if (pcEn_d) begin
      stepCnt_d = stepCnt_q + 1'b1;
    end
  end

  // Status outputs are registered from the next state so they line up with
  // state_q; the step counter moves in the same cycle pc_en is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      divCnt_q  <= '0;
      pcEn_q    <= 1'b0;
      running_q <= 1'b0;
      stepCnt_q <= '0;
`ifdef STEP_RUN_BREAKPOINT_EN
      skip_q    <= 1'b0;
      halted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      divCnt_q  <= divCnt_d;
      pcEn_q    <= pcEn_d;
      running_q <= (state_d == ST_RUN);
      stepCnt_q <= stepCnt_d;
`ifdef STEP_RUN_BREAKPOINT_EN
      skip_q    <= skip_d;
      halted_q  <= (state_d == ST_BREAK);
`endif
    end
  end

  assign pc_en    = pcEn_q;
  assign running  = running_q;
  assign step_cnt = stepCnt_q;
`ifdef STEP_RUN_BREAKPOINT_EN
  assign halted_bp = halted_q;
`else
  assign halted_bp = 1'b0;
`endif

endmodule

// File: tb/tb_step_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_step_run_ctrl
//
// Directed bench for step_run_ctrl with default parameters (RATE_DIV3 = 4).
// Stimulus pushes the cycle and step count of every pulse it expects into a
// queue; an independent monitor on the falling edge pops one entry for every
// pc_en it sees. It also stands in for the processor by advancing mon_pc on
// each pulse. Status outputs are compared directly one time unit after the
// rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_step_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_tick;
  logic        run_tick;
  logic [1:0]  rate_sel;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [15:0] mon_pc = '0;
  logic        pc_en;
  logic        running;
  logic        halted_bp;
  logic [15:0] step_cnt;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] expCnt = '0;
  int          cycleCount = 0;
  int          checks = 0;
  int          passes = 0;
  logic        pcClear = 1'b1;

  step_run_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .step_tick (step_tick),
    .run_tick  (run_tick),
    .rate_sel  (rate_sel),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .mon_pc    (mon_pc),
    .pc_en     (pc_en),
    .running   (running),
    .halted_bp (halted_bp),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int cyc);
    exp_t e;
    expCnt = expCnt + 16'd1;
    e.cyc  = cyc;
    e.cnt  = expCnt;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic step, input logic run);
    step_tick = step;
    run_tick  = run;
    @(posedge clk);
    #1;
    step_tick = 1'b0;
    run_tick  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the oldest expectation in cycle and count.
  always @(negedge clk) begin
    exp_t e;
    if (pcClear) begin
      mon_pc = '0;
    end else if (reset && pc_en) begin
      mon_pc = mon_pc + 16'd1;
    end
    if (reset && pc_en) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_pulse: pc_en=1 at cycle %0d, expected no pulse",
                 cycleCount);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_cycle", cycleCount, e.cyc);
        checkOutput("pulse_step_cnt", step_cnt, e.cnt);
      end
    end
  end

  initial begin
    int e0;
    int n;
    reset     = 1'b0;
    step_tick = 1'b0;
    run_tick  = 1'b0;
    rate_sel  = 2'd3;
    bp_en     = 1'b0;
    bp_addr   = '0;

    // Reset state
    waitCycles(3);
    checkOutput("rst_pc_en", pc_en, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_halted", halted_bp, 0);
    checkOutput("rst_step_cnt", step_cnt, 0);
    reset = 1'b1;
    waitCycles(2);

    // Three single steps from IDLE
    for (int i = 0; i < 3; i++) begin
      pushExp(cycleCount + 1);
      applyStimulus(1'b1, 1'b0);
      waitCycles(2);
    end
    checkOutput("t1_step_cnt", step_cnt, 3);
    checkOutput("t1_running", running, 0);

    // Free-run at rate 3: a pulse every 4 cycles after entering RUN
    rate_sel = 2'd3;
    applyStimulus(1'b0, 1'b1);
    e0 = cycleCount;
    for (int k = 1; k <= 5; k++) pushExp(e0 + 4 * k);
    checkOutput("t2_running", running, 1);
    waitCycles(20);
    checkOutput("t2_step_cnt", step_cnt, 8);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_stopped", running, 0);
    waitCycles(12);
    checkOutput("t2_no_more_pulses", step_cnt, 8);

    // Simultaneous step and run ticks: run wins, no pulse
    rate_sel = 2'd0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("t4_running", running, 1);
    checkOutput("t4_pc_en", pc_en, 0);
    checkOutput("t4_step_cnt", step_cnt, 8);
    waitCycles(1000);

    // Rate switch mid-run: divider already past the new limit
    rate_sel = 2'd3;
    e0 = cycleCount;
    pushExp(e0 + 1);
    pushExp(e0 + 5);
    pushExp(e0 + 9);
    waitCycles(9);
    checkOutput("t5_step_cnt", step_cnt, 11);
    applyStimulus(1'b0, 1'b1);
    waitCycles(8);
    checkOutput("t5_stopped", running, 0);
    checkOutput("t5_step_cnt_after", step_cnt, 11);

    // Breakpoint at PC 5 with mon_pc advancing on each pulse from 0
    pcClear = 1'b0;
    bp_en   = 1'b1;
    bp_addr = 16'h0005;
    applyStimulus(1'b0, 1'b1);
    e0 = cycleCount;
`ifdef STEP_RUN_BREAKPOINT_EN
    for (int k = 1; k <= 5; k++) pushExp(e0 + 4 * k);
    waitCycles(21);
    checkOutput("t3_halted", halted_bp, 1);
    checkOutput("t3_running_halted", running, 0);
    checkOutput("t3_step_cnt_halt", step_cnt, 16);
    waitCycles(6);
    checkOutput("t3_still_halted", step_cnt, 16);
    applyStimulus(1'b0, 1'b1);
    e0 = cycleCount;
    checkOutput("t3_resumed", running, 1);
    checkOutput("t3_halt_cleared", halted_bp, 0);
    pushExp(e0 + 4);
    pushExp(e0 + 8);
    waitCycles(8);
    checkOutput("t3_past_bp", step_cnt, 18);
    checkOutput("t3_no_rehalt", halted_bp, 0);
    applyStimulus(1'b0, 1'b1);
    waitCycles(6);
`else
    for (int k = 1; k <= 6; k++) pushExp(e0 + 4 * k);
    waitCycles(24);
    checkOutput("t3_bp_ignored", halted_bp, 0);
    checkOutput("t3_still_running", running, 1);
    checkOutput("t3_step_cnt", step_cnt, 17);
    applyStimulus(1'b0, 1'b1);
    waitCycles(6);
    checkOutput("t3_stopped", running, 0);
    checkOutput("t3_step_cnt_after", step_cnt, 17);
`endif
    bp_en = 1'b0;

    // Counter wrap: back-to-back steps up to 0xFFFF, then one more
    n = 32'h0000_FFFF - int'(expCnt);
    for (int i = 0; i < n; i++) begin
      pushExp(cycleCount + 1);
      step_tick = 1'b1;
      @(posedge clk);
      #1;
    end
    step_tick = 1'b0;
    waitCycles(2);
    checkOutput("t6_pre_wrap", step_cnt, 16'hFFFF);
    pushExp(cycleCount + 1);
    applyStimulus(1'b1, 1'b0);
    waitCycles(2);
    checkOutput("t6_wrap", step_cnt, 0);

    // Reset asserted while a pulse is high
    step_tick = 1'b1;
    @(posedge clk);
    #1;
    step_tick = 1'b0;
    checkOutput("t6_pulse_high", pc_en, 1);
    checkOutput("t6_cnt_before_reset", step_cnt, 1);
    reset = 1'b0;
    #1;
    checkOutput("t6_async_pc_en", pc_en, 0);
    checkOutput("t6_async_step_cnt", step_cnt, 0);
    checkOutput("t6_async_running", running, 0);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(3);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
